// File: rtl/store_buffer_pkg.sv
// ============================================================================
// store_buffer_pkg : shared widths and FSM encoding for the store buffer
// Rev 1.0
// ============================================================================
`default_nettype none

package store_buffer_pkg;

   localparam int SB_DEPTH  = 4;
   localparam int SB_ADDR_W = 4;
   localparam int SB_DATA_W = 16;

   localparam logic [0:0] ST_NORMAL = 1'b0;
   localparam logic [0:0] ST_FLUSH  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/store_buffer_if.sv
// ============================================================================
// store_buffer_if : datapath load/store, flush and data-memory port bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface store_buffer_if
   import store_buffer_pkg::*;
#(
   parameter int ADDR_W = SB_ADDR_W,
   parameter int DATA_W = SB_DATA_W
) ();

   logic              st_valid;
   logic              st_ready;
   logic              ld_valid;
   logic              ld_ready;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] ld_data;
   logic              flush_req;
   logic              flush_done;
   logic              MemWrite;
   logic              MemRead;
   logic [ADDR_W-1:0] Address;
   logic [DATA_W-1:0] WriteData;
   logic [DATA_W-1:0] ReadData;

   // The buffer itself
   modport slave (
      input  st_valid, ld_valid, cpu_addr, cpu_wdata, flush_req, ReadData,
      output st_ready, ld_ready, ld_data, flush_done,
             MemWrite, MemRead, Address, WriteData
   );

   // Datapath plus data memory
   modport master (
      output st_valid, ld_valid, cpu_addr, cpu_wdata, flush_req, ReadData,
      input  st_ready, ld_ready, ld_data, flush_done,
             MemWrite, MemRead, Address, WriteData
   );

endinterface

`default_nettype wire

// File: rtl/sb_fwd_match.sv
// ============================================================================
// sb_fwd_match : finds the youngest buffered entry matching a load address
// Rev 1.0
// ============================================================================
`default_nettype none

module sb_fwd_match #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 4,
   parameter int DATA_W = 16
) (
   input  logic [$clog2(DEPTH)-1:0]     tail,
   input  logic [$clog2(DEPTH):0]       count,
   input  logic [ADDR_W-1:0]            addr,
   input  logic [DEPTH-1:0][ADDR_W-1:0] entry_addr,
   input  logic [DEPTH-1:0][DATA_W-1:0] entry_data,
   output logic                         hit,
   output logic [DATA_W-1:0]            data
);

   localparam int c_ptr_w = $clog2(DEPTH);
   localparam int c_cnt_w = c_ptr_w + 1;

   logic [c_ptr_w-1:0] w_idx;

   // Walk oldest to youngest so the youngest match is the last one written.
   always_comb begin
      hit   = 1'b0;
      data  = '0;
      w_idx = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         w_idx = tail - c_ptr_w'(k + 1);
         if ((c_cnt_w'(k) < count) && (entry_addr[w_idx] == addr)) begin
            hit  = 1'b1;
            data = entry_data[w_idx];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/store_buffer.sv
// ============================================================================
// store_buffer : posted-write FIFO in front of the data memory with
//                same-cycle loads and store-to-load forwarding
// Rev 1.0
// ============================================================================
`default_nettype none

module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int DEPTH  = SB_DEPTH,
   parameter int ADDR_W = SB_ADDR_W,
   parameter int DATA_W = SB_DATA_W
) (
   input  logic          clk,
   input  logic          rst_n,
   store_buffer_if.slave bus
);

   localparam int               c_ptr_w = $clog2(DEPTH);
   localparam int               c_cnt_w = c_ptr_w + 1;
   localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(DEPTH);

   logic [0:0]                 r_state;
   logic [c_ptr_w-1:0]         r_head;
   logic [c_ptr_w-1:0]         r_tail;
   logic [c_cnt_w-1:0]         r_count;
   logic [DEPTH-1:0][ADDR_W-1:0] r_addr;
   logic [DEPTH-1:0][DATA_W-1:0] r_data;

   logic              w_flushing;
   logic              w_full;
   logic              w_accept_ok;
   logic              w_ld_issue;
   logic              w_drain;
   logic              w_st_accept;
   logic              w_flush_done;
   logic              w_fwd_hit;
   logic [DATA_W-1:0] w_fwd_data;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [DATA_W-1:0] w_mem_wdata;

   assign w_flushing   = (r_state == ST_FLUSH);
   assign w_full       = (r_count == c_full);
   assign w_accept_ok  = !w_flushing && !w_full;
   assign w_ld_issue   = bus.ld_valid && w_accept_ok;
   // A full buffer stalls loads, so the memory port always goes to retirement then.
   assign w_drain      = (r_count != '0) && !w_ld_issue;
   assign w_st_accept  = bus.st_valid && w_accept_ok;
   assign w_flush_done = w_flushing && (r_count == '0);

   sb_fwd_match #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_fwd (
      .tail       (r_tail),
      .count      (r_count),
      .addr       (bus.cpu_addr),
      .entry_addr (r_addr),
      .entry_data (r_data),
      .hit        (w_fwd_hit),
      .data       (w_fwd_data)
   );

   always_comb begin
      w_mem_addr  = bus.cpu_addr;
      w_mem_wdata = '0;
      if (w_drain) begin
         w_mem_addr  = r_addr[r_head];
         w_mem_wdata = r_data[r_head];
      end
   end

   assign bus.st_ready   = w_accept_ok;
   assign bus.ld_ready   = w_accept_ok;
   assign bus.ld_data    = w_fwd_hit ? w_fwd_data : bus.ReadData;
   assign bus.flush_done = w_flush_done;
   assign bus.MemWrite   = w_drain;
   assign bus.MemRead    = w_ld_issue;
   assign bus.Address    = w_mem_addr;
   assign bus.WriteData  = w_mem_wdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_NORMAL;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_addr  <= '0;
         r_data  <= '0;
      end else begin
         if (w_st_accept) begin
            r_addr[r_tail] <= bus.cpu_addr;
            r_data[r_tail] <= bus.cpu_wdata;
            r_tail         <= r_tail + c_ptr_w'(1);
         end
         if (w_drain) begin
            r_head <= r_head + c_ptr_w'(1);
         end
         if (w_st_accept && !w_drain) begin
            r_count <= r_count + c_cnt_w'(1);
         end else if (!w_st_accept && w_drain) begin
            r_count <= r_count - c_cnt_w'(1);
         end
         case (r_state)
            ST_NORMAL: if (bus.flush_req)  r_state <= ST_FLUSH;
            ST_FLUSH:  if (w_flush_done)   r_state <= ST_NORMAL;
            default:                       r_state <= ST_NORMAL;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// ============================================================================
// tb_store_buffer : directed vector table, async-reset sequence and random
//                   traffic against a queue-based model of the store buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_store_buffer;

   logic clk;
   logic rst_n;
   logic preload;
   int   errors;
   int   checks;

   logic [15:0] mem  [16];
   logic [15:0] arch [16];

   typedef struct {
      logic [3:0]  a;
      logic [15:0] d;
   } ent_t;

   ent_t pend[$];
   bit   flushing;
   logic got_fd;

   typedef struct {
      logic        st, ld, fl;
      logic [3:0]  a;
      logic [15:0] wd;
      logic        e_str, e_ldr, e_mw, e_mr, e_fd;
      logic [3:0]  e_a;
      logic [15:0] e_wd, e_ld;
   } vec_t;

   vec_t tbl[$];

   store_buffer_if #(.ADDR_W(4), .DATA_W(16)) bus ();

   store_buffer #(
      .DEPTH  (4),
      .ADDR_W (4),
      .DATA_W (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data memory: combinational read, write on the rising edge.
   assign bus.ReadData = mem[bus.Address];
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 16; i++)
            mem[i] <= (i == 7) ? 16'h1111 : (16'hD000 | 16'(i));
      end else if (bus.MemWrite) begin
         mem[bus.Address] <= bus.WriteData;
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %h expected %h", nm, $time, got, exp);
      end
   endtask

   function automatic vec_t v(input logic st, ld, fl, input logic [3:0] a, input logic [15:0] wd,
                              input logic e_str, e_ldr, e_mw, e_mr, e_fd,
                              input logic [3:0] e_a, input logic [15:0] e_wd, e_ld);
      vec_t r;
      r.st = st; r.ld = ld; r.fl = fl; r.a = a; r.wd = wd;
      r.e_str = e_str; r.e_ldr = e_ldr; r.e_mw = e_mw; r.e_mr = e_mr; r.e_fd = e_fd;
      r.e_a = e_a; r.e_wd = e_wd; r.e_ld = e_ld;
      return r;
   endfunction

   task automatic drive(input logic st, ld, fl, input logic [3:0] a, input logic [15:0] wd);
      bus.st_valid  = st;
      bus.ld_valid  = ld;
      bus.flush_req = fl;
      bus.cpu_addr  = a;
      bus.cpu_wdata = wd;
   endtask

   // Reference: architectural memory view plus an ordered list of posted stores.
   task automatic model_cycle();
      bit   rdy, ld_iss, drn, e_fd, st_acc;
      ent_t h;
      @(negedge clk);
      rdy    = !flushing && (pend.size() < 4);
      ld_iss = bus.ld_valid && rdy;
      drn    = !ld_iss && (pend.size() > 0);
      e_fd   = flushing && (pend.size() == 0);
      st_acc = bus.st_valid && rdy;
      got_fd = bus.flush_done;
      chk("rnd_st_ready", 32'(bus.st_ready), 32'(rdy));
      chk("rnd_ld_ready", 32'(bus.ld_ready), 32'(rdy));
      chk("rnd_flush_done", 32'(bus.flush_done), 32'(e_fd));
      chk("rnd_memread", 32'(bus.MemRead), 32'(ld_iss));
      chk("rnd_memwrite", 32'(bus.MemWrite), 32'(drn));
      if (drn) begin
         h = pend[0];
         chk("rnd_drain_addr", 32'(bus.Address), 32'(h.a));
         chk("rnd_drain_data", 32'(bus.WriteData), 32'(h.d));
      end else begin
         chk("rnd_addr", 32'(bus.Address), 32'(bus.cpu_addr));
      end
      if (ld_iss)
         chk("rnd_ld_data", 32'(bus.ld_data), 32'(arch[bus.cpu_addr]));
      @(posedge clk);
      if (drn) void'(pend.pop_front());
      if (st_acc) begin
         h.a = bus.cpu_addr;
         h.d = bus.cpu_wdata;
         pend.push_back(h);
         arch[bus.cpu_addr] = bus.cpu_wdata;
      end
      if (flushing) begin
         if (e_fd) flushing = 1'b0;
      end else if (bus.flush_req) begin
         flushing = 1'b1;
      end
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t r;
      errors  = 0;
      checks  = 0;
      rst_n   = 1'b0;
      preload = 1'b1;
      drive(0, 0, 0, 4'h0, 16'h0);

      //          st ld fl a     wd        str ldr mw mr fd  e_a   e_wd      e_ld
      tbl.push_back(v(0, 0, 0, 4'h0, 16'h0000, 1, 1, 0, 0, 0, 4'h0, 16'h0000, 16'h0000));
      tbl.push_back(v(1, 0, 0, 4'h3, 16'h1234, 1, 1, 0, 0, 0, 4'h3, 16'h0000, 16'h0000));
      tbl.push_back(v(0, 0, 0, 4'h0, 16'h0000, 1, 1, 1, 0, 0, 4'h3, 16'h1234, 16'h0000));
      tbl.push_back(v(0, 0, 0, 4'h0, 16'h0000, 1, 1, 0, 0, 0, 4'h0, 16'h0000, 16'h0000));
      tbl.push_back(v(1, 1, 0, 4'h5, 16'hA5A5, 1, 1, 0, 1, 0, 4'h5, 16'h0000, 16'hD005));
      tbl.push_back(v(1, 1, 0, 4'h5, 16'hC3C3, 1, 1, 0, 1, 0, 4'h5, 16'h0000, 16'hA5A5));
      tbl.push_back(v(0, 1, 0, 4'h5, 16'h0000, 1, 1, 0, 1, 0, 4'h5, 16'h0000, 16'hC3C3));
      tbl.push_back(v(0, 0, 0, 4'h0, 16'h0000, 1, 1, 1, 0, 0, 4'h5, 16'hA5A5, 16'h0000));
      tbl.push_back(v(0, 0, 0, 4'h0, 16'h0000, 1, 1, 1, 0, 0, 4'h5, 16'hC3C3, 16'h0000));
      tbl.push_back(v(0, 0, 0, 4'h0, 16'h0000, 1, 1, 0, 0, 0, 4'h0, 16'h0000, 16'h0000));
      tbl.push_back(v(1, 1, 0, 4'h0, 16'h0A00, 1, 1, 0, 1, 0, 4'h0, 16'h0000, 16'hD000));
      tbl.push_back(v(1, 1, 0, 4'h1, 16'h0A01, 1, 1, 0, 1, 0, 4'h1, 16'h0000, 16'hD001));
      tbl.push_back(v(1, 1, 0, 4'h2, 16'h0A02, 1, 1, 0, 1, 0, 4'h2, 16'h0000, 16'hD002));
      tbl.push_back(v(1, 1, 0, 4'h3, 16'h0A03, 1, 1, 0, 1, 0, 4'h3, 16'h0000, 16'h1234));
      tbl.push_back(v(0, 1, 0, 4'h9, 16'h0000, 0, 0, 1, 0, 0, 4'h0, 16'h0A00, 16'h0000));
      tbl.push_back(v(0, 1, 0, 4'h9, 16'h0000, 1, 1, 0, 1, 0, 4'h9, 16'h0000, 16'hD009));
      tbl.push_back(v(0, 0, 0, 4'h0, 16'h0000, 1, 1, 1, 0, 0, 4'h1, 16'h0A01, 16'h0000));
      tbl.push_back(v(0, 0, 0, 4'h0, 16'h0000, 1, 1, 1, 0, 0, 4'h2, 16'h0A02, 16'h0000));
      tbl.push_back(v(0, 0, 0, 4'h0, 16'h0000, 1, 1, 1, 0, 0, 4'h3, 16'h0A03, 16'h0000));
      tbl.push_back(v(0, 0, 0, 4'h0, 16'h0000, 1, 1, 0, 0, 0, 4'h0, 16'h0000, 16'h0000));
      tbl.push_back(v(1, 1, 0, 4'h7, 16'h00FF, 1, 1, 0, 1, 0, 4'h7, 16'h0000, 16'h1111));
      tbl.push_back(v(0, 1, 0, 4'h7, 16'h0000, 1, 1, 0, 1, 0, 4'h7, 16'h0000, 16'h00FF));
      tbl.push_back(v(0, 0, 0, 4'h0, 16'h0000, 1, 1, 1, 0, 0, 4'h7, 16'h00FF, 16'h0000));
      tbl.push_back(v(0, 0, 0, 4'h0, 16'h0000, 1, 1, 0, 0, 0, 4'h0, 16'h0000, 16'h0000));
      tbl.push_back(v(1, 1, 0, 4'hA, 16'h0B0A, 1, 1, 0, 1, 0, 4'hA, 16'h0000, 16'hD00A));
      tbl.push_back(v(1, 1, 0, 4'hB, 16'h0B0B, 1, 1, 0, 1, 0, 4'hB, 16'h0000, 16'hD00B));
      tbl.push_back(v(1, 1, 0, 4'hC, 16'h0B0C, 1, 1, 0, 1, 0, 4'hC, 16'h0000, 16'hD00C));
      tbl.push_back(v(0, 1, 1, 4'hD, 16'h0000, 1, 1, 0, 1, 0, 4'hD, 16'h0000, 16'hD00D));
      tbl.push_back(v(1, 1, 0, 4'hD, 16'hFFFF, 0, 0, 1, 0, 0, 4'hA, 16'h0B0A, 16'h0000));
      tbl.push_back(v(1, 1, 0, 4'hD, 16'hFFFF, 0, 0, 1, 0, 0, 4'hB, 16'h0B0B, 16'h0000));
      tbl.push_back(v(0, 1, 1, 4'hD, 16'h0000, 0, 0, 1, 0, 0, 4'hC, 16'h0B0C, 16'h0000));
      tbl.push_back(v(0, 1, 0, 4'hD, 16'h0000, 0, 0, 0, 0, 1, 4'hD, 16'h0000, 16'h0000));
      tbl.push_back(v(0, 1, 0, 4'hD, 16'h0000, 1, 1, 0, 1, 0, 4'hD, 16'h0000, 16'hD00D));
      tbl.push_back(v(0, 0, 1, 4'h0, 16'h0000, 1, 1, 0, 0, 0, 4'h0, 16'h0000, 16'h0000));
      tbl.push_back(v(0, 0, 0, 4'h0, 16'h0000, 0, 0, 0, 0, 1, 4'h0, 16'h0000, 16'h0000));
      tbl.push_back(v(0, 0, 0, 4'h0, 16'h0000, 1, 1, 0, 0, 0, 4'h0, 16'h0000, 16'h0000));

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n   = 1'b1;
      preload = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < tbl.size(); i++) begin
         r = tbl[i];
         drive(r.st, r.ld, r.fl, r.a, r.wd);
         @(negedge clk);
         chk($sformatf("v%0d_st_ready", i), 32'(bus.st_ready), 32'(r.e_str));
         chk($sformatf("v%0d_ld_ready", i), 32'(bus.ld_ready), 32'(r.e_ldr));
         chk($sformatf("v%0d_memwrite", i), 32'(bus.MemWrite), 32'(r.e_mw));
         chk($sformatf("v%0d_memread", i), 32'(bus.MemRead), 32'(r.e_mr));
         chk($sformatf("v%0d_flush_done", i), 32'(bus.flush_done), 32'(r.e_fd));
         chk($sformatf("v%0d_address", i), 32'(bus.Address), 32'(r.e_a));
         if (r.e_mw || !r.e_mr)
            chk($sformatf("v%0d_writedata", i), 32'(bus.WriteData), 32'(r.e_wd));
         if (r.e_mr)
            chk($sformatf("v%0d_ld_data", i), 32'(bus.ld_data), 32'(r.e_ld));
         @(posedge clk);
         #1;
      end

      // Two stores held in the buffer by back-to-back loads, then async reset.
      drive(1, 1, 0, 4'h1, 16'h7777);
      @(posedge clk); #1;
      drive(1, 1, 0, 4'h2, 16'h8888);
      @(posedge clk); #1;
      drive(0, 0, 0, 4'h0, 16'h0000);
      #1;
      chk("pre_reset_memwrite", 32'(bus.MemWrite), 32'd1);
      chk("pre_reset_addr", 32'(bus.Address), 32'h1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_st_ready", 32'(bus.st_ready), 32'd1);
      chk("async_rst_ld_ready", 32'(bus.ld_ready), 32'd1);
      chk("async_rst_memwrite", 32'(bus.MemWrite), 32'd0);
      chk("async_rst_memread", 32'(bus.MemRead), 32'd0);
      chk("async_rst_flush_done", 32'(bus.flush_done), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("post_rst_memwrite_%0d", i), 32'(bus.MemWrite), 32'd0);
      end
      chk("post_rst_mem1", 32'(mem[1]), 32'h0A01);
      chk("post_rst_mem2", 32'(mem[2]), 32'h0A02);
      @(posedge clk);
      #1;

      // Random traffic against the model.
      for (int i = 0; i < 16; i++) arch[i] = mem[i];
      flushing = 1'b0;
      pend.delete();
      for (int n = 0; n < 800; n++) begin
         drive(($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 29) == 0), 4'($urandom_range(0, 7)), 16'($urandom));
         model_cycle();
      end

      drive(0, 0, 1, 4'h0, 16'h0000);
      model_cycle();
      drive(0, 0, 0, 4'h0, 16'h0000);
      got_fd = 1'b0;
      for (int n = 0; n < 12 && !got_fd; n++) model_cycle();
      chk("final_flush_done_seen", 32'(got_fd), 32'd1);
      for (int i = 0; i < 16; i++)
         chk($sformatf("final_mem_%0d", i), 32'(mem[i]), 32'(arch[i]));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
